spike_rate_decoder: RTL and testbench



---
 rtl/spike_rate_decoder.sv | 140 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate and inter-spike-interval decoder (option: SPIKE_EDGE_DETECT_EN)
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 4,
    parameter int CNT_W       = 8,
    parameter int ISI_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             spike_in,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [ISI_W-1:0] last_isi,
    output logic             isi_valid
);

    localparam logic [WINDOW_LOG2-1:0] WIN_MAX = '1;
    localparam logic [WINDOW_LOG2-1:0] WIN_ONE = WINDOW_LOG2'(1);

    logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ISI_W-1:0]       isi_cnt_q, isi_cnt_d;
    logic                   seen_spike_q, seen_spike_d;
    logic [CNT_W-1:0]       rate_out_q, rate_out_d;
    logic                   rate_sat_q, rate_sat_d;
    logic                   rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0]       last_isi_q, last_isi_d;
    logic                   isi_valid_q, isi_valid_d;

    logic                   s;
    logic [CNT_W:0]         cnt_sum;
    logic [CNT_W-1:0]       cnt_next;
    logic [ISI_W:0]         isi_sum;
    logic [ISI_W-1:0]       isi_next;

`ifdef SPIKE_EDGE_DETECT_EN
    logic spike_d_q, spike_d_d;

    // A held-high pulse only counts on its first enabled cycle
    assign s = spike_in & ~spike_d_q;

    // Previous enabled-cycle spike level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) spike_d_q <= 1'b0;
        else        spike_d_q <= spike_d_d;
    end

    // spike_d follows the input only while enabled, and forgets on clear
    always_comb begin
        spike_d_d = spike_d_q;
        if (clear)    spike_d_d = 1'b0;
        else if (ena) spike_d_d = spike_in;
    end
`else
    assign s = spike_in;
`endif

    // Saturating increments; the extra top bit flags overflow
    assign cnt_sum  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, s};
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign isi_sum  = {1'b0, isi_cnt_q} + {{ISI_W{1'b0}}, 1'b1};
    assign isi_next = isi_sum[ISI_W] ? '1 : isi_sum[ISI_W-1:0];

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q    <= '0;
            cnt_q        <= '0;
            isi_cnt_q    <= '0;
            seen_spike_q <= 1'b0;
            rate_out_q   <= '0;
            rate_sat_q   <= 1'b0;
            rate_valid_q <= 1'b0;
            last_isi_q   <= '0;
            isi_valid_q  <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            cnt_q        <= cnt_d;
            isi_cnt_q    <= isi_cnt_d;
            seen_spike_q <= seen_spike_d;
            rate_out_q   <= rate_out_d;
            rate_sat_q   <= rate_sat_d;
            rate_valid_q <= rate_valid_d;
            last_isi_q   <= last_isi_d;
            isi_valid_q  <= isi_valid_d;
        end
    end

    // Next-state: clear beats everything, ena gates all counting
    always_comb begin
        win_cnt_d    = win_cnt_q;
        cnt_d        = cnt_q;
        isi_cnt_d    = isi_cnt_q;
        seen_spike_d = seen_spike_q;
        rate_out_d   = rate_out_q;
        rate_sat_d   = rate_sat_q;
        last_isi_d   = last_isi_q;
        rate_valid_d = 1'b0;
        isi_valid_d  = 1'b0;

        if (clear) begin
            win_cnt_d    = '0;
            cnt_d        = '0;
            isi_cnt_d    = '0;
            seen_spike_d = 1'b0;
        end else if (ena) begin
            if (win_cnt_q == WIN_MAX) begin
                // Window closes; the spike in this final cycle is included
                rate_out_d   = cnt_next;
                rate_sat_d   = cnt_sum[CNT_W];
                rate_valid_d = 1'b1;
                cnt_d        = '0;
                win_cnt_d    = '0;
            end else begin
                cnt_d        = cnt_next;
                win_cnt_d    = win_cnt_q + WIN_ONE;
            end

            if (s) begin
                isi_cnt_d    = '0;
                seen_spike_d = 1'b1;
                if (seen_spike_q) begin
                    last_isi_d  = isi_next;
                    isi_valid_d = 1'b1;
                end
            end else begin
                isi_cnt_d = isi_next;
            end
        end
    end

    assign rate_out   = rate_out_q;
    assign rate_sat   = rate_sat_q;
    assign rate_valid = rate_valid_q;
    assign last_isi   = last_isi_q;
    assign isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - self-checking bench for spike_rate_decoder
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       clear = 1'b0;
    logic       spike_in = 1'b0;
    logic [7:0] rate_out;
    logic       rate_valid, rate_sat, isi_valid;
    logic [7:0] last_isi;
    logic [2:0] rate_out3;
    logic       rate_valid3, rate_sat3, isi_valid3;
    logic [7:0] last_isi3;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_LOG2(4), .CNT_W(8), .ISI_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike_in(spike_in),
        .rate_out(rate_out), .rate_valid(rate_valid), .rate_sat(rate_sat),
        .last_isi(last_isi), .isi_valid(isi_valid)
    );

    spike_rate_decoder #(.WINDOW_LOG2(4), .CNT_W(3), .ISI_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike_in(spike_in),
        .rate_out(rate_out3), .rate_valid(rate_valid3), .rate_sat(rate_sat3),
        .last_isi(last_isi3), .isi_valid(isi_valid3)
    );

    typedef struct {
        logic       sp;
        logic       rv;
        logic [7:0] ro;
        logic       iv;
        logic [7:0] li;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic e, input logic c, input logic sp);
        ena = e;
        clear = c;
        spike_in = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ena = 1'b0;
        clear = 1'b0;
        spike_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Spikes every 4 cycles, hand-computed outputs after each edge
        for (int i = 0; i < 16; i++) begin
            vt[i].sp = ((i % 4) == 0);
            vt[i].rv = (i == 15);
            vt[i].ro = (i == 15) ? 8'd4 : 8'd0;
            vt[i].iv = ((i % 4) == 0) && (i > 0);
            vt[i].li = (i >= 4) ? 8'd4 : 8'd0;
        end

        do_reset();
        chk("reset_rate_out", {24'd0, rate_out}, 32'd0);
        chk("reset_strobes", {30'd0, rate_valid, isi_valid}, 32'd0);
        chk("reset_last_isi", {24'd0, last_isi}, 32'd0);
        chk("reset_rate_sat", {31'd0, rate_sat}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, vt[i].sp);
            chk($sformatf("vec%0d", i),
                {14'd0, rate_valid, rate_out, isi_valid, last_isi},
                {14'd0, vt[i].rv, vt[i].ro, vt[i].iv, vt[i].li});
        end

        // spike held 16 cycles: rate 16 (8-bit), saturated 7 (3-bit)
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk($sformatf("hold_rv%0d", i), {31'd0, rate_valid}, {31'd0, (i == 15)});
        end
        chk("hold_rate_out", {24'd0, rate_out}, 32'd16);
        chk("hold_rate_sat", {31'd0, rate_sat}, 32'd0);
        chk("sat3_rate_out", {29'd0, rate_out3}, 32'd7);
        chk("sat3_rate_sat", {31'd0, rate_sat3}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("hold_rv_one_cycle", {31'd0, rate_valid}, 32'd0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
        chk("zero_win_rv", {31'd0, rate_valid}, 32'd1);
        chk("zero_win_rate_out", {24'd0, rate_out}, 32'd0);
        chk("sat3_zero_rate_out", {29'd0, rate_out3}, 32'd0);
        chk("sat3_zero_rate_sat", {31'd0, rate_sat3}, 32'd0);

        // ena=0 for 10 cycles mid-window freezes everything
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("ena0_strobes%0d", i), {30'd0, rate_valid, isi_valid}, 32'd0);
        end
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("ena_win_rv%0d", i), {31'd0, rate_valid}, {31'd0, (i == 10)});
        end
        chk("ena_win_rate_out", {24'd0, rate_out}, 32'd5);
        chk("ena_win_last_isi", {24'd0, last_isi}, 32'd1);

        // clear coinciding with window end and a spike
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_strobes", {30'd0, rate_valid, isi_valid}, 32'd0);
        chk("clr_rate_out_hold", {24'd0, rate_out}, 32'd5);
        chk("clr_last_isi_hold", {24'd0, last_isi}, 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("clr_first_spike_iv", {31'd0, isi_valid}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk($sformatf("clr_win_rv%0d", i), {31'd0, rate_valid}, 32'd0);
        end
        step(1'b1, 1'b0, 1'b1);
        chk("clr_next_rv", {31'd0, rate_valid}, 32'd1);
        chk("clr_next_rate_out", {24'd0, rate_out}, 32'd16);

        // asynchronous reset mid-cycle clears outputs without a clock edge
        step(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rate_out", {24'd0, rate_out}, 32'd0);
        chk("async_last_isi", {24'd0, last_isi}, 32'd0);
        chk("async_strobes", {30'd0, rate_valid, isi_valid}, 32'd0);
        chk("async_rate_out3", {29'd0, rate_out3}, 32'd0);
        do_reset();

`ifdef SPIKE_EDGE_DETECT_EN
        // a 5-cycle high pulse counts once
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);
        chk("edge_rv", {31'd0, rate_valid}, 32'd1);
        chk("edge_rate_out", {24'd0, rate_out}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
